// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the adder-sharing controller: FSM states, widths and
// the round-robin pointer increment.
package add_share_pkg;

  localparam int W        = 64;
  localparam int MAX_NREQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle between the issue ports (master) and the shared
// adder controller (slave).
interface adder_share_ctrl_if
  import add_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_last;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
  );

endinterface

// File: rtl/adder_share_ctrl_csel_add.sv
// 64-bit carry-select adder: each 16-bit block precomputes both carry cases
// and the incoming block carry picks one.
module add_csel64
  import add_share_pkg::*;
#(
  parameter int BLK = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  localparam int NBLK = W / BLK;

  logic [NBLK:0] blk_c;
  assign blk_c[0] = cin_i;

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    assign s0 = {1'b0, a_i[gi*BLK +: BLK]} + {1'b0, b_i[gi*BLK +: BLK]};
    assign s1 = {1'b0, a_i[gi*BLK +: BLK]} + {1'b0, b_i[gi*BLK +: BLK]} + (BLK+1)'(1);
    assign sum_o[gi*BLK +: BLK] = blk_c[gi] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign blk_c[gi+1]          = blk_c[gi] ? s1[BLK]     : s0[BLK];
  end

  assign cout_o = blk_c[NBLK];

endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    if (en_i) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (32'(ptr_i) + 32'(k)) % 32'(NREQ);
        if (!any_o && req_i[cand]) begin
          any_o       = 1'b1;
          idx_o       = IDW'(cand);
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Arbitrates one shared 64-bit adder among NREQ requesters, supporting
// multi-beat carry chains, with a single registered valid/ready result stage.
module adder_share_ctrl
  import add_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  adder_share_ctrl_if.slave bus
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           carry_q, carry_d;

  logic           rsp_valid_q;
  logic [W-1:0]   rsp_sum_q;
  logic           rsp_cout_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_last_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  logic            out_free;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic            cin_sel;
  logic            beat_last;
  logic [NREQ-1:0] req_ready;
  logic [W-1:0]    op_a, op_b, add_sum;
  logic            add_cout;

  logic [W-1:0] op_a_arr [NREQ];
  logic [W-1:0] op_b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a_arr[gi] = bus.req_a[gi*W +: W];
    assign op_b_arr[gi] = bus.req_b[gi*W +: W];
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  add_csel64 u_add (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (cin_sel),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign out_free = !rsp_valid_q || bus.rsp_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      carry_q   <= carry_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    carry_d   = carry_q;
    if (xfer) begin
      if (beat_last) begin
        state_d  = IDLE;
        rr_ptr_d = IDW'(next_rr(32'(gnt_idx), NREQ));
      end else begin
        state_d   = LOCK;
        lock_id_d = gnt_idx;
        carry_d   = add_cout;
      end
    end
  end

  // Output logic: grant, operand mux and carry-in source
  always_comb begin
    gnt_idx = arb_idx;
    gnt_any = arb_any;
    cin_sel = bus.req_cin[arb_idx];
    if (state_q == LOCK) begin
      gnt_idx = lock_id_q;
      gnt_any = bus.req_valid[lock_id_q];
      cin_sel = carry_q;
    end
    xfer      = gnt_any && out_free;
    beat_last = bus.req_last[gnt_idx];
    op_a      = op_a_arr[gnt_idx];
    op_b      = op_b_arr[gnt_idx];
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_sum_q   <= add_sum;
      rsp_cout_q  <= add_cout;
      rsp_id_q    <= gnt_idx;
      rsp_last_q  <= beat_last;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized bench for adder_share_ctrl against a transaction-level model of
// arbitration, chaining and the one-deep result stage.
module tb_adder_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;

  adder_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the adder, the carry being propagated, the round-robin
  // start point and what the result register should show.
  bit          m_locked;
  int          m_owner;
  bit          m_carry;
  int          m_ptr;
  bit          m_valid;
  logic [63:0] m_sum;
  bit          m_cout;
  int          m_id;
  bit          m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_carry = 0; m_ptr = 0;
    m_valid = 0; m_sum = '0; m_cout = 0; m_id = 0; m_last = 0;
  endtask

  // One clock: check combinational ready at negedge, advance the model,
  // then check the registered response just after the rising edge.
  task automatic cycle();
    bit              out_free, have;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0]    a, b;
    logic [W:0]      full;
    bit              cin;
    @(negedge clk);
    out_free = !m_valid || bus.rsp_ready;
    have = 0;
    g = 0;
    if (m_locked) begin
      if (bus.req_valid[m_owner]) begin have = 1; g = m_owner; end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (!have && bus.req_valid[idx]) begin have = 1; g = idx; end
      end
    end
    exp_rdy = '0;
    if (have && out_free) exp_rdy[g] = 1'b1;
    check("req_ready", bus.req_ready, exp_rdy);
    if (have && out_free) begin
      a    = bus.req_a[g*W +: W];
      b    = bus.req_b[g*W +: W];
      cin  = m_locked ? m_carry : bus.req_cin[g];
      full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      m_valid = 1;
      m_sum   = full[W-1:0];
      m_cout  = full[W];
      m_id    = g;
      m_last  = bus.req_last[g];
      $display("beat req=%0d a=%h b=%h cin=%0d last=%0d -> sum=%h cout=%0d",
               g, a, b, cin, m_last, m_sum, m_cout);
      if (m_last) begin
        m_locked = 0;
        m_ptr    = (g + 1) % NREQ;
      end else begin
        m_locked = 1;
        m_owner  = g;
        m_carry  = m_cout;
      end
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", bus.rsp_valid, m_valid);
    if (m_valid) begin
      check("rsp_sum",  bus.rsp_sum,  m_sum);
      check("rsp_cout", bus.rsp_cout, m_cout);
      check("rsp_id",   bus.rsp_id,   m_id);
      check("rsp_last", bus.rsp_last, m_last);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_last  = '0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", bus.rsp_valid, 0);
    check("reset_sum",   bus.rsp_sum,   0);
    check("reset_cout",  bus.rsp_cout,  0);
    check("reset_id",    bus.rsp_id,    0);
    check("reset_last",  bus.rsp_last,  0);
    check("reset_ready", bus.req_ready, 0);
    rst = 1'b0;

    // Single add with overflow into carry-out
    bus.req_valid[0]  = 1'b1;
    bus.req_a[0 +: W] = '1;
    bus.req_b[0 +: W] = 64'd1;
    bus.req_cin[0]    = 1'b0;
    bus.req_last[0]   = 1'b1;
    bus.rsp_ready     = 1'b1;
    cycle();
    check("single_valid", bus.rsp_valid, 1);
    check("single_sum",   bus.rsp_sum,   0);
    check("single_cout",  bus.rsp_cout,  1);
    check("single_id",    bus.rsp_id,    0);
    bus.req_valid = '0;
    cycle();
    check("single_drop", bus.rsp_valid, 0);

    // Open a chain, then reset asynchronously while locked with a result pending
    bus.req_valid[0] = 1'b1;
    bus.req_last[0]  = 1'b0;
    cycle();
    check("chain_valid", bus.rsp_valid, 1);
    bus.req_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("async_valid", bus.rsp_valid, 0);
    check("async_sum",   bus.rsp_sum,   0);
    check("async_cout",  bus.rsp_cout,  0);
    check("async_ready", bus.req_ready, 0);
    rst = 1'b0;
    model_reset();

    // After reset requester 0 wins and its own carry-in applies
    bus.req_valid      = 4'b0101;
    bus.req_a[0 +: W]  = 64'd1;
    bus.req_b[0 +: W]  = 64'd1;
    bus.req_cin[0]     = 1'b1;
    bus.req_last       = 4'b1111;
    bus.rsp_ready      = 1'b1;
    cycle();
    check("post_reset_id",  bus.rsp_id,  0);
    check("post_reset_sum", bus.rsp_sum, 3);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
        rb = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
        bus.req_valid[i]  = ($urandom_range(0, 9) < 7);
        bus.req_last[i]   = $urandom_range(0, 1) == 1;
        bus.req_cin[i]    = $urandom_range(0, 1) == 1;
        bus.req_a[i*W +: W] = ra;
        bus.req_b[i*W +: W] = rb;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
